// File: rtl/mem_arb2.sv
// Two-client round-robin front end for a single-port-pair memory.
// Zero-fills every word after reset, then grants one access per cycle.
module mem_arb2 #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned MAX_ADDR   = 16,
   parameter int unsigned ADDRSIZE   = $clog2(MAX_ADDR)
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic                  init_done,
   input  logic                  c0_valid,
   output logic                  c0_ready,
   input  logic                  c0_we,
   input  logic [ADDRSIZE-1:0]   c0_addr,
   input  logic [DATA_WIDTH-1:0] c0_wdata,
   output logic                  c0_rvalid,
   output logic [DATA_WIDTH-1:0] c0_rdata,
   input  logic                  c1_valid,
   output logic                  c1_ready,
   input  logic                  c1_we,
   input  logic [ADDRSIZE-1:0]   c1_addr,
   input  logic [DATA_WIDTH-1:0] c1_wdata,
   output logic                  c1_rvalid,
   output logic [DATA_WIDTH-1:0] c1_rdata,
   output logic                  mem_rd_en,
   output logic [ADDRSIZE-1:0]   mem_rd_addr,
   output logic                  mem_wr_en,
   output logic [ADDRSIZE-1:0]   mem_wr_addr,
   output logic [DATA_WIDTH-1:0] mem_wr_data,
   input  logic [DATA_WIDTH-1:0] mem_rd_data
);

   localparam int unsigned CMP_W = ADDRSIZE + 1;
   localparam logic [ADDRSIZE-1:0] LAST_ADDR = ADDRSIZE'(MAX_ADDR - 1);
   localparam logic [CMP_W-1:0]    DEPTH     = CMP_W'(MAX_ADDR);

   typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t                state_q, state_d;
   logic [ADDRSIZE-1:0]   clr_cnt_q, clr_cnt_d;
   logic                  rr_ptr_q, rr_ptr_d;
   logic                  rvalid0_q, rvalid1_q;
   logic                  run_ok;
   logic                  grant0, grant1;
   logic                  sel_we;
   logic [ADDRSIZE-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic                  in_range;
   logic [DATA_WIDTH-1:0] rd_val;

   // Round-robin grant: a lone requester always wins, contention goes to rr_ptr.
   assign run_ok = !rst && (state_q == RUN);
   assign grant0 = run_ok && c0_valid && (!c1_valid || !rr_ptr_q);
   assign grant1 = run_ok && c1_valid && (!c0_valid ||  rr_ptr_q);
   assign c0_ready = grant0;
   assign c1_ready = grant1;

   assign sel_we    = grant1 ? c1_we    : c0_we;
   assign sel_addr  = grant1 ? c1_addr  : c0_addr;
   assign sel_wdata = grant1 ? c1_wdata : c0_wdata;
   // Addresses past the depth are accepted but never reach the memory.
   assign in_range  = {1'b0, sel_addr} < DEPTH;
   assign rd_val    = in_range ? mem_rd_data : '0;

   // A pending response is dropped as soon as reset is seen.
   assign c0_rvalid = rvalid0_q && !rst;
   assign c1_rvalid = rvalid1_q && !rst;

   always_comb begin
      state_d     = state_q;
      clr_cnt_d   = clr_cnt_q;
      rr_ptr_d    = rr_ptr_q;
      mem_rd_en   = 1'b0;
      mem_rd_addr = sel_addr;
      mem_wr_en   = 1'b0;
      mem_wr_addr = sel_addr;
      mem_wr_data = sel_wdata;
      if (!rst) begin
         case (state_q)
            CLEAR: begin
               mem_wr_en   = 1'b1;
               mem_wr_addr = clr_cnt_q;
               mem_wr_data = '0;
               clr_cnt_d   = clr_cnt_q + 1'b1;
               if (clr_cnt_q == LAST_ADDR) state_d = RUN;
            end
            RUN: begin
               if (grant0 || grant1) begin
                  rr_ptr_d  = grant0;
                  mem_wr_en = sel_we && in_range;
                  mem_rd_en = !sel_we && in_range;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= CLEAR;
         clr_cnt_q <= '0;
         rr_ptr_q  <= 1'b0;
         init_done <= 1'b0;
         rvalid0_q <= 1'b0;
         rvalid1_q <= 1'b0;
         c0_rdata  <= '0;
         c1_rdata  <= '0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         rr_ptr_q  <= rr_ptr_d;
         init_done <= (state_d == RUN);
         rvalid0_q <= grant0 && !c0_we;
         rvalid1_q <= grant1 && !c1_we;
         if (grant0 && !c0_we) c0_rdata <= rd_val;
         if (grant1 && !c1_we) c1_rdata <= rd_val;
      end
   end

endmodule

// File: tb/tb_mem_arb2.sv
// Bench for mem_arb2: a 16-word instance for fill/arbitration/reset scenarios
// and a 12-word instance for out-of-range handling, each with its own memory.
module tb_mem_arb2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, preload, mon_en;
   logic       c0_valid, c0_we, c1_valid, c1_we;
   logic [3:0] c0_addr, c1_addr;
   logic [7:0] c0_wdata, c1_wdata;
   logic       init_done, c0_ready, c1_ready, c0_rvalid, c1_rvalid;
   logic [7:0] c0_rdata, c1_rdata;
   logic       mem_rd_en, mem_wr_en;
   logic [3:0] mem_rd_addr, mem_wr_addr;
   logic [7:0] mem_wr_data, mem_rd_data;

   logic       b0_valid, b0_we, b1_valid, b1_we;
   logic [3:0] b0_addr, b1_addr;
   logic [7:0] b0_wdata, b1_wdata;
   logic       b_init_done, b0_ready, b1_ready, b0_rvalid, b1_rvalid;
   logic [7:0] b0_rdata, b1_rdata;
   logic       b_rd_en, b_wr_en;
   logic [3:0] b_rd_addr, b_wr_addr;
   logic [7:0] b_wr_data, b_rd_data;

   logic [7:0] mem16 [16];
   logic [7:0] mem12 [16];
   logic [7:0] model_mem [16];

   typedef struct {
      int         client;
      logic [7:0] data;
      int         due;
   } exp_t;
   exp_t sbq[$];

   int nvec = 0;
   int nmis = 0;
   int cyc  = 0;

   mem_arb2 #(.DATA_WIDTH(8), .MAX_ADDR(16)) dut (
      .clk(clk), .rst(rst), .init_done(init_done),
      .c0_valid(c0_valid), .c0_ready(c0_ready), .c0_we(c0_we), .c0_addr(c0_addr),
      .c0_wdata(c0_wdata), .c0_rvalid(c0_rvalid), .c0_rdata(c0_rdata),
      .c1_valid(c1_valid), .c1_ready(c1_ready), .c1_we(c1_we), .c1_addr(c1_addr),
      .c1_wdata(c1_wdata), .c1_rvalid(c1_rvalid), .c1_rdata(c1_rdata),
      .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr), .mem_wr_en(mem_wr_en),
      .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data)
   );

   mem_arb2 #(.DATA_WIDTH(8), .MAX_ADDR(12)) dut12 (
      .clk(clk), .rst(rst), .init_done(b_init_done),
      .c0_valid(b0_valid), .c0_ready(b0_ready), .c0_we(b0_we), .c0_addr(b0_addr),
      .c0_wdata(b0_wdata), .c0_rvalid(b0_rvalid), .c0_rdata(b0_rdata),
      .c1_valid(b1_valid), .c1_ready(b1_ready), .c1_we(b1_we), .c1_addr(b1_addr),
      .c1_wdata(b1_wdata), .c1_rvalid(b1_rvalid), .c1_rdata(b1_rdata),
      .mem_rd_en(b_rd_en), .mem_rd_addr(b_rd_addr), .mem_wr_en(b_wr_en),
      .mem_wr_addr(b_wr_addr), .mem_wr_data(b_wr_data), .mem_rd_data(b_rd_data)
   );

   // Memories: combinational read, write at the clock edge, garbage preload.
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 16; i++) begin
            mem16[i] <= 8'hFF;
            mem12[i] <= 8'h55;
         end
      end else begin
         if (mem_wr_en) mem16[mem_wr_addr] <= mem_wr_data;
         if (b_wr_en)   mem12[b_wr_addr]   <= b_wr_data;
      end
   end
   assign mem_rd_data = mem16[mem_rd_addr];
   assign b_rd_data   = mem12[b_rd_addr];

   always @(posedge clk) cyc <= cyc + 1;

   // Response checker for the 16-word instance: rvalid must appear exactly when due.
   always @(negedge clk) begin
      exp_t e;
      logic ev0, ev1;
      if (mon_en) begin
         ev0 = 1'b0;
         ev1 = 1'b0;
         e   = '{client: 0, data: 8'h00, due: 0};
         if (sbq.size() > 0 && sbq[0].due == cyc) begin
            e   = sbq.pop_front();
            ev0 = (e.client == 0);
            ev1 = (e.client == 1);
         end
         nvec++;
         if ({c0_rvalid, c1_rvalid} !== {ev0, ev1}) begin
            nmis++;
            $display("FAIL rvalid_seq cyc %0d got %b%b want %b%b", cyc, c0_rvalid, c1_rvalid, ev0, ev1);
         end
         if (ev0) begin
            nvec++;
            if (c0_rdata !== e.data) begin
               nmis++;
               $display("FAIL c0_rdata cyc %0d got %h want %h", cyc, c0_rdata, e.data);
            end
         end
         if (ev1) begin
            nvec++;
            if (c1_rdata !== e.data) begin
               nmis++;
               $display("FAIL c1_rdata cyc %0d got %h want %h", cyc, c1_rdata, e.data);
            end
         end
      end
   end

   task automatic push(input int client, input logic [7:0] data);
      sbq.push_back('{client: client, data: data, due: cyc + 1});
   endtask

   task automatic test_reset();
      c0_valid = 1'b1; c0_we = 1'b0; c0_addr = 4'd1;
      c1_valid = 1'b1; c1_we = 1'b1; c1_addr = 4'd2; c1_wdata = 8'h99;
      @(posedge clk); #1;
      preload = 1'b0;
      mon_en  = 1'b1;
      @(negedge clk);
      nvec++;
      if ({init_done, c0_ready, c1_ready, mem_wr_en, mem_rd_en, c0_rdata, c1_rdata} !== 21'h0) begin
         nmis++;
         $display("FAIL reset_state got %b%b%b%b%b %h %h want 00000 00 00", init_done, c0_ready,
                  c1_ready, mem_wr_en, mem_rd_en, c0_rdata, c1_rdata);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         nvec++;
         if ({mem_wr_en, mem_rd_en, c0_ready, c1_ready, init_done, mem_wr_addr, mem_wr_data} !==
             {5'b10000, 4'(i), 8'h00}) begin
            nmis++;
            $display("FAIL fill step %0d got en%b rd%b rdy%b%b done%b a%h d%h", i, mem_wr_en,
                     mem_rd_en, c0_ready, c1_ready, init_done, mem_wr_addr, mem_wr_data);
         end
         @(posedge clk); #1;
      end
      c0_valid = 1'b0;
      c1_valid = 1'b0;
      @(negedge clk);
      nvec++;
      if ({init_done, b_init_done, mem_wr_en} !== 3'b110) begin
         nmis++;
         $display("FAIL init_done got %b%b%b want 110", init_done, b_init_done, mem_wr_en);
      end
      for (int i = 0; i < 16; i++) begin
         model_mem[i] = 8'h00;
         nvec++;
         if (mem16[i] !== 8'h00) begin
            nmis++;
            $display("FAIL zero_fill word %0d got %h want 00", i, mem16[i]);
         end
      end
      @(posedge clk); #1;
   endtask

   task automatic test_write_read();
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 4'd3; c0_wdata = 8'hA5;
      @(negedge clk);
      nvec++;
      if ({c0_ready, c1_ready, mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data} !== {4'b1010, 4'd3, 8'hA5}) begin
         nmis++;
         $display("FAIL wr_grant got %b%b%b%b %h %h want 1010 3 a5", c0_ready, c1_ready,
                  mem_wr_en, mem_rd_en, mem_wr_addr, mem_wr_data);
      end
      model_mem[3] = 8'hA5;
      @(posedge clk); #1;
      c0_we = 1'b0;
      @(negedge clk);
      nvec++;
      if ({c0_ready, c1_ready, mem_wr_en, mem_rd_en, mem_rd_addr} !== {4'b1001, 4'd3}) begin
         nmis++;
         $display("FAIL rd_grant got %b%b%b%b %h want 1001 3", c0_ready, c1_ready, mem_wr_en,
                  mem_rd_en, mem_rd_addr);
      end
      push(0, model_mem[3]);
      @(posedge clk); #1;
      c0_valid = 1'b0;
      @(negedge clk);
      nvec++;
      if ({c0_rvalid, c1_rvalid, c0_rdata} !== {2'b10, 8'hA5}) begin
         nmis++;
         $display("FAIL raw_resp got %b%b %h want 10 a5", c0_rvalid, c1_rvalid, c0_rdata);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_alternate();
      c0_valid = 1'b1; c0_we = 1'b1; c0_addr = 4'd1; c0_wdata = 8'h11;
      @(negedge clk);
      nvec++;
      if ({c0_ready, c1_ready, mem_wr_en, mem_wr_addr, mem_wr_data} !== {3'b101, 4'd1, 8'h11}) begin
         nmis++;
         $display("FAIL preload_c0 got %b%b%b %h %h want 101 1 11", c0_ready, c1_ready,
                  mem_wr_en, mem_wr_addr, mem_wr_data);
      end
      model_mem[1] = 8'h11;
      @(posedge clk); #1;
      c0_valid = 1'b0;
      c1_valid = 1'b1; c1_we = 1'b1; c1_addr = 4'd2; c1_wdata = 8'h22;
      @(negedge clk);
      nvec++;
      if ({c0_ready, c1_ready, mem_wr_en, mem_wr_addr, mem_wr_data} !== {3'b011, 4'd2, 8'h22}) begin
         nmis++;
         $display("FAIL preload_c1 got %b%b%b %h %h want 011 2 22", c0_ready, c1_ready,
                  mem_wr_en, mem_wr_addr, mem_wr_data);
      end
      model_mem[2] = 8'h22;
      @(posedge clk); #1;
      c0_valid = 1'b1; c0_we = 1'b0; c0_addr = 4'd1;
      c1_we = 1'b0; c1_addr = 4'd2;
      for (int k = 0; k < 6; k++) begin
         logic g0;
         g0 = (k % 2 == 0);
         @(negedge clk);
         nvec++;
         if ({c0_ready, c1_ready, mem_rd_en, mem_rd_addr} !== {g0, !g0, 1'b1, (g0 ? 4'd1 : 4'd2)}) begin
            nmis++;
            $display("FAIL alternate k%0d got %b%b%b %h want %b%b1", k, c0_ready, c1_ready,
                     mem_rd_en, mem_rd_addr, g0, !g0);
         end
         push(g0 ? 0 : 1, g0 ? model_mem[1] : model_mem[2]);
         @(posedge clk); #1;
      end
      c0_valid = 1'b0;
      c1_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_c1_alone();
      c0_valid = 1'b1; c0_we = 1'b0; c0_addr = 4'd1;
      @(negedge clk);
      nvec++;
      if ({c0_ready, c1_ready} !== 2'b10) begin
         nmis++;
         $display("FAIL c0_single got %b%b want 10", c0_ready, c1_ready);
      end
      push(0, model_mem[1]);
      @(posedge clk); #1;
      c0_valid = 1'b0;
      c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 4'd2;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         nvec++;
         if ({c0_ready, c1_ready, mem_rd_en, mem_rd_addr} !== {3'b011, 4'd2}) begin
            nmis++;
            $display("FAIL c1_alone k%0d got %b%b%b %h want 011 2", k, c0_ready, c1_ready,
                     mem_rd_en, mem_rd_addr);
         end
         push(1, model_mem[2]);
         @(posedge clk); #1;
      end
      c0_valid = 1'b1;
      @(negedge clk);
      nvec++;
      if ({c0_ready, c1_ready} !== 2'b10) begin
         nmis++;
         $display("FAIL rr_after_c1 got %b%b want 10", c0_ready, c1_ready);
      end
      push(0, model_mem[1]);
      @(posedge clk); #1;
      c0_valid = 1'b0;
      c1_valid = 1'b0;
      @(negedge clk);
      nvec++;
      if ({mem_rd_en, mem_wr_en, c0_ready, c1_ready} !== 4'b0000) begin
         nmis++;
         $display("FAIL idle got %b%b%b%b want 0000", mem_rd_en, mem_wr_en, c0_ready, c1_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_fill();
      rst = 1'b1;
      @(negedge clk);
      nvec++;
      if ({mem_wr_en, mem_rd_en, c0_ready, c1_ready} !== 4'b0000) begin
         nmis++;
         $display("FAIL rst_outputs got %b%b%b%b want 0000", mem_wr_en, mem_rd_en, c0_ready, c1_ready);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 4'd2;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         nvec++;
         if ({mem_wr_en, c1_ready, mem_wr_addr} !== {2'b10, 4'(i)}) begin
            nmis++;
            $display("FAIL prefill step %0d got %b%b %h", i, mem_wr_en, c1_ready, mem_wr_addr);
         end
         @(posedge clk); #1;
      end
      rst = 1'b1;
      @(negedge clk);
      nvec++;
      if ({mem_wr_en, c1_ready, init_done} !== 3'b000) begin
         nmis++;
         $display("FAIL rst_step5 got %b%b%b want 000", mem_wr_en, c1_ready, init_done);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         nvec++;
         if ({mem_wr_en, c0_ready, c1_ready, init_done, mem_wr_addr, mem_wr_data} !==
             {4'b1000, 4'(i), 8'h00}) begin
            nmis++;
            $display("FAIL refill step %0d got %b%b%b%b %h %h", i, mem_wr_en, c0_ready,
                     c1_ready, init_done, mem_wr_addr, mem_wr_data);
         end
         @(posedge clk); #1;
      end
      for (int i = 0; i < 16; i++) model_mem[i] = 8'h00;
      @(negedge clk);
      nvec++;
      if ({init_done, c0_ready, c1_ready, mem_rd_en, mem_rd_addr} !== {4'b1011, 4'd2}) begin
         nmis++;
         $display("FAIL held_request got %b%b%b%b %h want 1011 2", init_done, c0_ready,
                  c1_ready, mem_rd_en, mem_rd_addr);
      end
      push(1, model_mem[2]);
      @(posedge clk); #1;
      c1_valid = 1'b0;
   endtask

   task automatic test_reset_after_read();
      c0_valid = 1'b1; c0_we = 1'b0; c0_addr = 4'd3;
      @(negedge clk);
      nvec++;
      if (c0_ready !== 1'b1) begin
         nmis++;
         $display("FAIL pre_rst_grant got %b want 1", c0_ready);
      end
      @(posedge clk); #1;
      rst = 1'b1;
      c0_valid = 1'b0;
      @(negedge clk);
      nvec++;
      if ({c0_rvalid, c1_rvalid} !== 2'b00) begin
         nmis++;
         $display("FAIL dropped_rvalid got %b%b want 00", c0_rvalid, c1_rvalid);
      end
      @(posedge clk); #1;
      rst = 1'b0;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         nvec++;
         if ({mem_wr_en, init_done, c0_rvalid, mem_wr_addr} !== {3'b100, 4'(i)}) begin
            nmis++;
            $display("FAIL refill2 step %0d got %b%b%b %h", i, mem_wr_en, init_done, c0_rvalid, mem_wr_addr);
         end
         @(posedge clk); #1;
      end
      c0_valid = 1'b1; c0_we = 1'b0; c0_addr = 4'd1;
      c1_valid = 1'b1; c1_we = 1'b0; c1_addr = 4'd2;
      @(negedge clk);
      nvec++;
      if ({c0_ready, c1_ready} !== 2'b10) begin
         nmis++;
         $display("FAIL rr_reset got %b%b want 10", c0_ready, c1_ready);
      end
      push(0, model_mem[1]);
      @(posedge clk); #1;
      c0_valid = 1'b0;
      c1_valid = 1'b0;
      @(negedge clk);
      @(posedge clk); #1;
   endtask

   task automatic test_out_of_range();
      b0_valid = 1'b1; b0_we = 1'b1; b0_addr = 4'd11; b0_wdata = 8'h33;
      @(negedge clk);
      nvec++;
      if ({b_init_done, b0_ready, b_wr_en, b_wr_addr} !== {3'b111, 4'd11}) begin
         nmis++;
         $display("FAIL top_word_wr got %b%b%b %h want 111 b", b_init_done, b0_ready, b_wr_en, b_wr_addr);
      end
      @(posedge clk); #1;
      b0_we = 1'b0;
      @(negedge clk);
      nvec++;
      if ({b0_ready, b_rd_en, b_rd_addr} !== {2'b11, 4'd11}) begin
         nmis++;
         $display("FAIL top_word_rd got %b%b %h want 11 b", b0_ready, b_rd_en, b_rd_addr);
      end
      @(posedge clk); #1;
      b0_we = 1'b1; b0_addr = 4'd13; b0_wdata = 8'h7E;
      @(negedge clk);
      nvec++;
      if ({b0_rvalid, b1_rvalid, b0_rdata, b0_ready, b_wr_en} !== {2'b10, 8'h33, 2'b10}) begin
         nmis++;
         $display("FAIL oor_wr got rv%b%b %h rdy%b wen%b want 10 33 1 0", b0_rvalid, b1_rvalid,
                  b0_rdata, b0_ready, b_wr_en);
      end
      @(posedge clk); #1;
      b0_we = 1'b0;
      @(negedge clk);
      nvec++;
      if ({b0_ready, b_rd_en, b_wr_en} !== 3'b100) begin
         nmis++;
         $display("FAIL oor_rd_grant got %b%b%b want 100", b0_ready, b_rd_en, b_wr_en);
      end
      @(posedge clk); #1;
      b0_valid = 1'b0;
      @(negedge clk);
      nvec++;
      if ({b0_rvalid, b1_rvalid, b0_rdata, mem12[13]} !== {2'b10, 8'h00, 8'h55}) begin
         nmis++;
         $display("FAIL oor_resp got %b%b %h mem %h want 10 00 55", b0_rvalid, b1_rvalid,
                  b0_rdata, mem12[13]);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; preload = 1'b1; mon_en = 1'b0;
      c0_valid = 1'b0; c0_we = 1'b0; c0_addr = '0; c0_wdata = '0;
      c1_valid = 1'b0; c1_we = 1'b0; c1_addr = '0; c1_wdata = '0;
      b0_valid = 1'b0; b0_we = 1'b0; b0_addr = '0; b0_wdata = '0;
      b1_valid = 1'b0; b1_we = 1'b0; b1_addr = '0; b1_wdata = '0;
      test_reset();
      test_write_read();
      test_alternate();
      test_c1_alone();
      test_reset_mid_fill();
      test_reset_after_read();
      test_out_of_range();
      repeat (2) @(posedge clk);
      #1;
      nvec++;
      if (sbq.size() != 0) begin
         nmis++;
         $display("FAIL sb_drain got %0d pending want 0", sbq.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
